// File: rtl/itype_pkg.sv
// -----------------------------------------------------------------------------
// itype_pkg
// Shared definitions for the I-type execute unit: opcode values, FSM state
// type, instruction field positions and small decode helpers.
// Optional feature macro used by the top: ITYPE_TRAP_EN.
// -----------------------------------------------------------------------------
package itype_pkg;

   // Supported I-type opcodes
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   // Instruction field positions
   localparam int unsigned OPC_MSB = 31;
   localparam int unsigned OPC_LSB = 26;
   localparam int unsigned RS_MSB  = 25;
   localparam int unsigned RS_LSB  = 21;
   localparam int unsigned RT_MSB  = 20;
   localparam int unsigned RT_LSB  = 16;
   localparam int unsigned IMM_MSB = 15;
   localparam int unsigned IMM_LSB = 0;

   // Register address width
   localparam int unsigned REG_AW = 5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DEC,
      S_EXE,
      S_WB
   } state_t;

   // Opcodes whose immediate is sign-extended; everything else zero-extends
   function automatic logic imm_is_signed(input logic [5:0] op);
      return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI);
   endfunction

endpackage

// File: rtl/itype_regfile.sv
// -----------------------------------------------------------------------------
// itype_regfile
// NREGS x XLEN register file, one synchronous write port, two asynchronous
// read ports (operand and debug). Register 0 always reads zero and is never
// written. Synchronous active-low reset clears every register.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   we, waddr, wdata     write port
//   raddr, rdata         operand read port (combinational)
//   dbg_addr, dbg_data   debug read port (combinational)
// -----------------------------------------------------------------------------
module itype_regfile
   import itype_pkg::*;
#(
   parameter int unsigned NREGS = 32,
   parameter int unsigned XLEN  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [XLEN-1:0]   wdata,
   input  logic [REG_AW-1:0] raddr,
   output logic [XLEN-1:0]   rdata,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [XLEN-1:0]   dbg_data
);

   logic [XLEN-1:0] mem [NREGS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata    = (raddr == '0)    ? '0 : mem[raddr];
      dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
   end

endmodule

// File: rtl/itype_exec_unit.sv
// -----------------------------------------------------------------------------
// itype_exec_unit
// Multi-cycle MIPS I-type front end: accepts an instruction word over
// valid/ready, decodes it, reads rs, extends the immediate, executes and
// writes the result back to rt. Sequence IDLE -> DEC -> EXE -> WB -> IDLE,
// one instruction per 4 cycles.
// Optional feature macro: ITYPE_TRAP_EN (overflowing addi suppresses the
// writeback and sets a sticky trap that blocks further accepts until reset).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid, in_ready    instruction handshake
//   instr                 opcode[31:26] rs[25:21] rt[20:16] imm[15:0]
//   pl_en/pl_addr/pl_data register preload (honoured only in IDLE)
//   done                  one-cycle pulse during writeback
//   result/overflow/illegal  outcome of the last instruction, valid with done
//   dbg_addr, dbg_data    combinational register read
// -----------------------------------------------------------------------------
module itype_exec_unit
   import itype_pkg::*;
#(
   parameter int unsigned NREGS = 32,
   parameter int unsigned XLEN  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   input  logic              pl_en,
   input  logic [REG_AW-1:0] pl_addr,
   input  logic [XLEN-1:0]   pl_data,
   output logic              done,
   output logic [XLEN-1:0]   result,
   output logic              overflow,
   output logic              illegal,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [XLEN-1:0]   dbg_data
);

   state_t state, state_next;

   logic [31:0]       instr_q;
   logic [XLEN-1:0]   opa_q;
   logic [XLEN-1:0]   imm_q;
   logic [XLEN-1:0]   res_q;
   logic              ovf_q;
   logic              ill_q;

   logic              accept;
   logic              dec_en;
   logic              exe_en;
   logic              wb_en;
   logic              trap_block;

   logic [5:0]        opcode;
   logic [REG_AW-1:0] rs;
   logic [REG_AW-1:0] rt;
   logic [15:0]       imm;

   logic [XLEN-1:0]   rs_data;
   logic [XLEN-1:0]   sum;
   logic [XLEN-1:0]   alu_res;
   logic              alu_ovf;
   logic              alu_ill;

   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [XLEN-1:0]   rf_wdata;
   logic              pl_we;

   assign opcode = instr_q[OPC_MSB:OPC_LSB];
   assign rs     = instr_q[RS_MSB:RS_LSB];
   assign rt     = instr_q[RT_MSB:RT_LSB];
   assign imm    = instr_q[IMM_MSB:IMM_LSB];

`ifdef ITYPE_TRAP_EN
   logic trap_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         trap_q <= 1'b0;
      end else if (wb_en && ovf_q) begin
         trap_q <= 1'b1;
      end
   end

   assign trap_block = trap_q;
`else
   assign trap_block = 1'b0;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      accept     = 1'b0;
      dec_en     = 1'b0;
      exe_en     = 1'b0;
      wb_en      = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = !trap_block;
            accept   = in_valid && !trap_block;
            if (accept) begin
               state_next = S_DEC;
            end
         end
         S_DEC: begin
            dec_en     = 1'b1;
            state_next = S_EXE;
         end
         S_EXE: begin
            exe_en     = 1'b1;
            state_next = S_WB;
         end
         S_WB: begin
            wb_en      = 1'b1;
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- ALU
   always_comb begin
      sum     = opa_q + imm_q;
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_ill = 1'b0;
      case (opcode)
         OP_ADDI: begin
            alu_res = sum;
            alu_ovf = (opa_q[XLEN-1] == imm_q[XLEN-1]) &&
                      (sum[XLEN-1] != opa_q[XLEN-1]);
         end
         OP_ADDIU: alu_res = sum;
         OP_SLTI:  alu_res = XLEN'($signed(opa_q) < $signed(imm_q));
         OP_ANDI:  alu_res = opa_q & imm_q;
         OP_ORI:   alu_res = opa_q | imm_q;
         OP_LUI:   alu_res = XLEN'({imm, 16'h0000});
         default:  alu_ill = 1'b1;
      endcase
   end

   // ----------------------------------------------------------- datapath
   // The outcome registers load on the EXE->WB edge so that result and the
   // flags are already valid in the cycle done pulses; they then hold until
   // the next instruction reaches WB.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr_q <= '0;
         opa_q   <= '0;
         imm_q   <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         if (accept) begin
            instr_q <= instr;
         end
         if (dec_en) begin
            opa_q <= rs_data;
            imm_q <= imm_is_signed(opcode) ? XLEN'($signed(imm)) : XLEN'(imm);
         end
         if (exe_en) begin
            res_q <= alu_res;
            ovf_q <= alu_ovf;
            ill_q <= alu_ill;
         end
      end
   end

   assign result   = res_q;
   assign overflow = ovf_q;
   assign illegal  = ill_q;

   // ---------------------------------------------------------- writeback
   // Preload and writeback never coincide (IDLE vs WB), so a simple mux
   // shares the single write port. A preload on the accept edge lands before
   // the DEC-cycle read of rs.
`ifdef ITYPE_TRAP_EN
   logic wb_suppress;
   assign wb_suppress = ill_q || ovf_q;
`else
   logic wb_suppress;
   assign wb_suppress = ill_q;
`endif

   assign pl_we    = pl_en && (state == S_IDLE);
   assign rf_we    = (wb_en && !wb_suppress) || pl_we;
   assign rf_waddr = wb_en ? rt    : pl_addr;
   assign rf_wdata = wb_en ? res_q : pl_data;

   itype_regfile #(
      .NREGS (NREGS),
      .XLEN  (XLEN)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (rf_we),
      .waddr    (rf_waddr),
      .wdata    (rf_wdata),
      .raddr    (rs),
      .rdata    (rs_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

endmodule
